// File: rtl/uwoc_rx_pkg.sv
// Shared FSM encodings and default sync-word settings for the UWOC RX deframer.
package uwoc_rx_pkg;
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SEARCH  = 3'd1;
   localparam logic [2:0] ST_VERIFY  = 3'd2;
   localparam logic [2:0] ST_LEN     = 3'd3;
   localparam logic [2:0] ST_PAYLOAD = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;
   localparam logic [2:0] ST_FAIL    = 3'd6;

   localparam int          SYNC_W_DEF       = 16;
   localparam logic [31:0] SYNC_PATTERN_DEF = 32'h0000_AABB;
endpackage

// File: rtl/uwoc_frame_deframer_if.sv
// Bit stream in, payload bytes out; master = bit source / byte sink, slave = deframer.
interface uwoc_frame_deframer_if;
   logic       bit_in;
   logic       bit_vld;
   logic [7:0] byte_out;
   logic       byte_vld;
   logic       frame_done;

   modport master (output bit_in, bit_vld, input byte_out, byte_vld, frame_done);
   modport slave  (input bit_in, bit_vld, output byte_out, byte_vld, frame_done);
endinterface

// File: rtl/uwoc_sync_match.sv
// Combinational sync-word compare: match when Hamming distance to pattern <= max_err.
module uwoc_sync_match #(
   parameter int SYNC_W = 16
) (
   input  logic [SYNC_W-1:0]             word,
   input  logic [SYNC_W-1:0]             pattern,
   input  logic [$clog2(SYNC_W+1)-1:0]   max_err,
   output logic                          match
);
   localparam int ERR_W = $clog2(SYNC_W+1);

   logic [SYNC_W-1:0] diff;
   logic [ERR_W-1:0]  errs;

   always_comb begin
      diff = word ^ pattern;
      errs = '0;
      for (int i = 0; i < SYNC_W; i++) begin
         errs = errs + ERR_W'(diff[i]);
      end
      match = (errs <= max_err);
   end
endmodule

// File: rtl/uwoc_frame_deframer.sv
// Frame sync (tolerant, repeated sync words) + length-driven deframer; auto re-arms after each frame.
// Optional inverted-polarity lock with UWOC_DEFRAME_POLINV_EN.
module uwoc_frame_deframer
   import uwoc_rx_pkg::*;
#(
   parameter int                SYNC_W       = SYNC_W_DEF,
   parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(SYNC_PATTERN_DEF),
   parameter int                LEN_W        = 16,
   parameter int                REP_W        = 4
) (
   input  logic                           clk_130M,
   input  logic                           rst,
   input  logic                           rx_en,
   uwoc_frame_deframer_if.slave           bus,
   input  logic [$clog2(SYNC_W+1)-1:0]    cfg_max_err,
   input  logic [REP_W-1:0]               cfg_reps,
   input  logic [15:0]                    cfg_timeout_bits,
   output logic                           sync_ok,
   output logic                           sync_fail,
   output logic                           pol_inv,
   output logic [LEN_W-1:0]               len_out,
   output logic [2:0]                     dbg_state
);
   localparam int WC_W = $clog2(SYNC_W);
   localparam int LC_W = $clog2(LEN_W);

   logic [2:0]        state;
   // sreg keeps the previous SYNC_W-1 bits; the current bit completes the window.
   logic [SYNC_W-2:0] sreg;
   logic [SYNC_W-1:0] nsreg;
   logic [WC_W-1:0]   wcnt;
   logic [REP_W-1:0]  rep, rep_nx, reps_eff;
   logic [15:0]       tcnt, tcnt_nx;
   logic [LC_W-1:0]   lcnt;
   logic [LEN_W-1:0]  len_nx, bcnt;
   logic [2:0]        bitcnt;
   logic [6:0]        bsh;
   logic [7:0]        bsh_nx, byte_q;
   logic              byte_vld_q, frame_done_q, pol_q;
   logic              b, match_t, match_i, timeout_hit;

   assign reps_eff    = (cfg_reps == '0) ? REP_W'(1) : cfg_reps;
   assign b           = bus.bit_in ^ pol_q;
   assign nsreg       = {sreg, b};
   assign len_nx      = {len_out[LEN_W-2:0], b};
   assign bsh_nx      = {bsh, b};
   assign rep_nx      = rep + REP_W'(1);
   assign tcnt_nx     = tcnt + 16'd1;
   assign timeout_hit = (cfg_timeout_bits != 16'd0) && (tcnt_nx == cfg_timeout_bits);

   uwoc_sync_match #(.SYNC_W(SYNC_W)) u_match_t (
      .word(nsreg), .pattern(SYNC_PATTERN), .max_err(cfg_max_err), .match(match_t));

`ifdef UWOC_DEFRAME_POLINV_EN
   uwoc_sync_match #(.SYNC_W(SYNC_W)) u_match_i (
      .word(nsreg), .pattern(~SYNC_PATTERN), .max_err(cfg_max_err), .match(match_i));
`else
   assign match_i = 1'b0;
`endif

   always_ff @(posedge clk_130M) begin
      byte_vld_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (rst || !rx_en) begin
         state     <= ST_IDLE;
         sreg      <= '0;
         wcnt      <= '0;
         rep       <= '0;
         tcnt      <= '0;
         lcnt      <= '0;
         bcnt      <= '0;
         bitcnt    <= '0;
         bsh       <= '0;
         byte_q    <= '0;
         len_out   <= '0;
         sync_ok   <= 1'b0;
         sync_fail <= 1'b0;
         pol_q     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: state <= ST_SEARCH;
            ST_SEARCH: if (bus.bit_vld) begin
               sreg <= nsreg[SYNC_W-2:0];
               wcnt <= '0;
               if ((match_t || match_i) && reps_eff == REP_W'(1)) begin
                  pol_q   <= ~match_t;
                  rep     <= REP_W'(1);
                  tcnt    <= '0;
                  lcnt    <= '0;
                  sync_ok <= 1'b1;
                  state   <= ST_LEN;
               end else if (timeout_hit) begin
                  tcnt      <= '0;
                  sync_fail <= 1'b1;
                  state     <= ST_FAIL;
               end else if (match_t || match_i) begin
                  pol_q <= ~match_t;
                  rep   <= REP_W'(1);
                  tcnt  <= tcnt_nx;
                  state <= ST_VERIFY;
               end else begin
                  tcnt <= tcnt_nx;
               end
            end
            ST_VERIFY: if (bus.bit_vld) begin
               sreg <= nsreg[SYNC_W-2:0];
               wcnt <= wcnt + WC_W'(1);
               if (wcnt == WC_W'(SYNC_W-1) && match_t && rep_nx == reps_eff) begin
                  rep     <= rep_nx;
                  tcnt    <= '0;
                  lcnt    <= '0;
                  sync_ok <= 1'b1;
                  state   <= ST_LEN;
               end else if (timeout_hit) begin
                  tcnt      <= '0;
                  sync_fail <= 1'b1;
                  state     <= ST_FAIL;
               end else if (wcnt == WC_W'(SYNC_W-1)) begin
                  wcnt <= '0;
                  tcnt <= tcnt_nx;
                  if (match_t) begin
                     rep <= rep_nx;
                  end else begin
                     // Hand the raw (un-corrected) history back so the search resumes seamlessly.
                     sreg  <= nsreg[SYNC_W-2:0] ^ {(SYNC_W-1){pol_q}};
                     pol_q <= 1'b0;
                     rep   <= '0;
                     state <= ST_SEARCH;
                  end
               end else begin
                  tcnt <= tcnt_nx;
               end
            end
            ST_LEN: if (bus.bit_vld) begin
               len_out <= len_nx;
               lcnt    <= lcnt + LC_W'(1);
               bcnt    <= '0;
               bitcnt  <= '0;
               if (lcnt == LC_W'(LEN_W-1)) begin
                  if (len_nx == '0) begin
                     frame_done_q <= 1'b1;
                     sync_ok      <= 1'b0;
                     state        <= ST_DONE;
                  end else begin
                     state <= ST_PAYLOAD;
                  end
               end
            end
            ST_PAYLOAD: if (bus.bit_vld) begin
               bsh    <= bsh_nx[6:0];
               bitcnt <= bitcnt + 3'd1;
               if (bitcnt == 3'd7) begin
                  byte_q     <= bsh_nx;
                  byte_vld_q <= 1'b1;
                  bcnt       <= bcnt + LEN_W'(1);
                  if (bcnt == len_out - LEN_W'(1)) begin
                     frame_done_q <= 1'b1;
                     sync_ok      <= 1'b0;
                     state        <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               sreg  <= '0;
               wcnt  <= '0;
               rep   <= '0;
               tcnt  <= '0;
               pol_q <= 1'b0;
               state <= ST_SEARCH;
            end
            ST_FAIL: state <= ST_FAIL;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.byte_out   = byte_q;
   assign bus.byte_vld   = byte_vld_q;
   assign bus.frame_done = frame_done_q;
   assign pol_inv        = pol_q;
   assign dbg_state      = state;
endmodule
